// File: rtl/frame_row_sequencer_if.sv
// Word stream into the frame row sequencer: data/valid from the source, ready back from the sequencer.
interface frame_row_sequencer_if #(
  parameter int unsigned FrameBitsPerRow = 32
) ();
  logic [FrameBitsPerRow-1:0] s_data;
  logic                       s_valid;
  logic                       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_row_sequencer.sv
// Splits a header-prefixed word stream into per-row frame writes followed by a single frame commit strobe.
// A header carries the frame address; an out-of-range address swallows the frame and sets a sticky error flag.
module frame_row_sequencer #(
  parameter int unsigned FrameBitsPerRow  = 32,
  parameter int unsigned RowSelectWidth   = 5,
  parameter int unsigned NumRows          = 15,
  parameter int unsigned FrameSelectWidth = 5,
  parameter int unsigned MaxFramesPerCol  = 20
) (
  input  logic                        CLK,
  input  logic                        resetn,
  frame_row_sequencer_if.slave        stream,
  output logic [FrameBitsPerRow-1:0]  FrameData_O,
  output logic [RowSelectWidth-1:0]   RowSelect,
  output logic [FrameSelectWidth-1:0] FrameAddr,
  output logic                        FrameStrobe,
  output logic                        busy,
  output logic                        addr_err,
  output logic [15:0]                 frames_done
);

  localparam int unsigned HdrMsb = 31;
  localparam int unsigned HdrLsb = 24;
  localparam logic [7:0]  HdrTag = 8'hFA;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STROBE, SKIP} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [RowSelectWidth-1:0]   row_cnt;
  logic                        ready_q;

  logic [RowSelectWidth-1:0]   row_cnt_next;
  logic [RowSelectWidth-1:0]   row_sel_next;
  logic [FrameBitsPerRow-1:0]  data_next;
  logic [FrameSelectWidth-1:0] addr_next;
  logic                        strobe_next;
  logic                        err_next;
  logic [15:0]                 done_next;
  logic                        ready_next;
  logic                        busy_next;

  logic                        accept;
  logic                        is_hdr;
  logic [FrameSelectWidth-1:0] hdr_addr;
  logic                        addr_ok;
  logic                        last_row;

  assign stream.s_ready = ready_q;
  assign accept   = stream.s_valid && ready_q;
  assign is_hdr   = (stream.s_data[HdrMsb:HdrLsb] == HdrTag);
  assign hdr_addr = stream.s_data[FrameSelectWidth-1:0];
  assign addr_ok  = (32'(hdr_addr) < 32'(MaxFramesPerCol));
  assign last_row = (row_cnt == RowSelectWidth'(NumRows));

  // State register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_hdr) state_next = addr_ok ? LOAD : SKIP;
      LOAD:    if (accept && last_row) state_next = DRAIN;
      DRAIN:   state_next = STROBE;
      STROBE:  state_next = IDLE;
      SKIP:    if (accept && last_row) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and row counter
  always_comb begin
    row_cnt_next = row_cnt;
    row_sel_next = '0;
    data_next    = FrameData_O;
    addr_next    = FrameAddr;
    strobe_next  = 1'b0;
    err_next     = addr_err;
    done_next    = frames_done;
    case (state)
      IDLE: begin
        if (accept && is_hdr) begin
          row_cnt_next = RowSelectWidth'(1);
          if (addr_ok) addr_next = hdr_addr;
          else         err_next  = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          row_sel_next = row_cnt;
          data_next    = stream.s_data;
          row_cnt_next = last_row ? '0 : row_cnt + RowSelectWidth'(1);
        end
      end
      DRAIN: begin
        // Commit pulse lands in STROBE together with the new count
        strobe_next = 1'b1;
        done_next   = frames_done + 16'd1;
      end
      SKIP: begin
        if (accept) row_cnt_next = last_row ? '0 : row_cnt + RowSelectWidth'(1);
      end
      default: ;
    endcase
    ready_next = (state_next == IDLE) || (state_next == LOAD) || (state_next == SKIP);
    busy_next  = (state_next != IDLE);
  end

  // Output and counter registers
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_cnt     <= '0;
      RowSelect   <= '0;
      FrameData_O <= '0;
      FrameAddr   <= '0;
      FrameStrobe <= 1'b0;
      addr_err    <= 1'b0;
      frames_done <= '0;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
    end else begin
      row_cnt     <= row_cnt_next;
      RowSelect   <= row_sel_next;
      FrameData_O <= data_next;
      FrameAddr   <= addr_next;
      FrameStrobe <= strobe_next;
      addr_err    <= err_next;
      frames_done <= done_next;
      ready_q     <= ready_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_frame_row_sequencer.sv
// Directed bench for frame_row_sequencer: normal, gapped, bad-address, idle-drop and mid-frame reset cases.
module tb_frame_row_sequencer;

  logic        CLK;
  logic        resetn;
  logic [31:0] FrameData_O;
  logic [4:0]  RowSelect;
  logic [4:0]  FrameAddr;
  logic        FrameStrobe;
  logic        busy;
  logic        addr_err;
  logic [15:0] frames_done;

  int checks;
  int failures;
  logic [15:0] exp_done;

  frame_row_sequencer_if #(.FrameBitsPerRow(32)) bus ();

  frame_row_sequencer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .stream      (bus),
    .FrameData_O (FrameData_O),
    .RowSelect   (RowSelect),
    .FrameAddr   (FrameAddr),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .addr_err    (addr_err),
    .frames_done (frames_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Header, NumRows words (optionally with an idle cycle before each), then DRAIN and STROBE.
  task automatic run_frame(input logic [4:0] addr, input logic [31:0] base, input bit gap);
    logic [31:0] last_data;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hFA00_0000 | 32'(addr);
    tick();
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_addr", 32'(FrameAddr), 32'(addr));
    check("hdr_row", 32'(RowSelect), 32'd0);
    last_data = FrameData_O;
    for (int k = 1; k <= 15; k++) begin
      if (gap) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 32'hDEAD_0000 + 32'(k);
        tick();
        check("gap_row", 32'(RowSelect), 32'd0);
        check("gap_data", FrameData_O, last_data);
        check("gap_strobe", 32'(FrameStrobe), 32'd0);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = base + 32'(k - 1);
      tick();
      check("row_sel", 32'(RowSelect), 32'(k));
      check("row_data", FrameData_O, base + 32'(k - 1));
      check("row_strobe", 32'(FrameStrobe), 32'd0);
      last_data = base + 32'(k - 1);
    end
    check("drain_ready", 32'(bus.s_ready), 32'd0);
    // A header offered during DRAIN/STROBE must not be taken
    bus.s_data = 32'hFA00_0005;
    tick();
    exp_done = exp_done + 16'd1;
    check("strobe_pulse", 32'(FrameStrobe), 32'd1);
    check("strobe_row", 32'(RowSelect), 32'd0);
    check("strobe_done", 32'(frames_done), 32'(exp_done));
    check("strobe_addr", 32'(FrameAddr), 32'(addr));
    check("strobe_data", FrameData_O, base + 32'd14);
    check("strobe_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check("post_strobe", 32'(FrameStrobe), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_addr", 32'(FrameAddr), 32'(addr));
    check("post_ready", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_done    = 16'd0;
    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_row", 32'(RowSelect), 32'd0);
    check("rst_data", FrameData_O, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_done", 32'(frames_done), 32'd0);
    @(negedge CLK);
    resetn = 1'b1;
    tick();
    check("rst_ready", 32'(bus.s_ready), 32'd1);

    // Back-to-back frame
    run_frame(5'd3, 32'h100, 1'b0);

    // Same frame with valid toggling
    run_frame(5'd7, 32'h100, 1'b1);

    // Out-of-range header swallows NumRows words
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hFA00_0014;
    tick();
    check("bad_err", 32'(addr_err), 32'd1);
    check("bad_addr", 32'(FrameAddr), 32'd7);
    check("bad_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 15; k++) begin
      bus.s_data = 32'h200 + 32'(k);
      tick();
      check("skip_row", 32'(RowSelect), 32'd0);
      check("skip_strobe", 32'(FrameStrobe), 32'd0);
    end
    bus.s_valid = 1'b0;
    check("skip_busy", 32'(busy), 32'd0);
    check("skip_data", FrameData_O, 32'h10E);
    check("skip_done", 32'(frames_done), 32'(exp_done));

    // Highest legal address; error stays sticky
    run_frame(5'd19, 32'h300, 1'b0);
    check("sticky_err", 32'(addr_err), 32'd1);

    // Non-header words in IDLE are dropped
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h1234_5678;
    tick();
    check("drop1_busy", 32'(busy), 32'd0);
    check("drop1_row", 32'(RowSelect), 32'd0);
    bus.s_data = 32'h0000_0000;
    tick();
    check("drop2_busy", 32'(busy), 32'd0);
    bus.s_data = 32'hFB00_0003;
    tick();
    check("drop3_busy", 32'(busy), 32'd0);
    check("drop_data", FrameData_O, 32'h30E);
    check("drop_addr", 32'(FrameAddr), 32'd19);
    bus.s_valid = 1'b0;
    tick();

    // Reset after row 7 of a frame
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hFA00_0002;
    tick();
    for (int k = 1; k <= 7; k++) begin
      bus.s_data = 32'h400 + 32'(k - 1);
      tick();
    end
    check("mid_row", 32'(RowSelect), 32'd7);
    bus.s_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_row", 32'(RowSelect), 32'd0);
    check("arst_data", FrameData_O, 32'd0);
    check("arst_addr", 32'(FrameAddr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(addr_err), 32'd0);
    check("arst_done", 32'(frames_done), 32'd0);
    check("arst_strobe", 32'(FrameStrobe), 32'd0);
    @(negedge CLK);
    resetn   = 1'b1;
    exp_done = 16'd0;
    tick();
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_strobe", 32'(FrameStrobe), 32'd0);
    run_frame(5'd1, 32'h500, 1'b0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
